// File: rtl/rename_pkg.sv
// Shared rename-path definitions: physical register pool sizing and the
// register/mask types used by the free list and its priority encoder.
package rename_pkg;

    localparam int PREG_NUM = 64;                   // power of two
    localparam int AREG_NUM = 32;                   // identity-mapped at reset
    localparam int PREG_W   = $clog2(PREG_NUM);
    localparam int CNT_W    = PREG_W + 1;           // must be able to hold PREG_NUM

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [PREG_NUM-1:0] preg_mask_t;
    typedef logic [CNT_W-1:0]    count_t;

    // Free bitmap after reset: architectural pregs (including $zero) are busy.
    function automatic preg_mask_t reset_mask();
        preg_mask_t m;
        for (int i = 0; i < PREG_NUM; i++) begin
            m[i] = (i >= AREG_NUM);
        end
        return m;
    endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit side bundle of the physical register free list.
// master = rename/commit logic driving requests, slave = the free list.
interface phys_reg_free_list_if;
    import rename_pkg::*;

    logic   alloc_req;
    logic   alloc_gnt;
    preg_t  alloc_preg;
    logic   rel_valid;
    preg_t  rel_preg;
    count_t free_count;
    logic   empty;
    logic   err_double_free;
    logic   ckpt_save;
    logic   ckpt_restore;
    logic   ckpt_valid;

    modport master (
        output alloc_req, rel_valid, rel_preg, ckpt_save, ckpt_restore,
        input  alloc_gnt, alloc_preg, free_count, empty, err_double_free, ckpt_valid
    );

    modport slave (
        input  alloc_req, rel_valid, rel_preg, ckpt_save, ckpt_restore,
        output alloc_gnt, alloc_preg, free_count, empty, err_double_free, ckpt_valid
    );

endinterface

// File: rtl/lowest_free_finder.sv
// Combinational priority encoder: returns the lowest set bit of a preg mask.
module lowest_free_finder
    import rename_pkg::*;
(
    input  preg_mask_t mask,
    output logic       found,
    output preg_t      preg
);

    // lower_any[k] = some bit below position k is set
    logic [PREG_NUM:0]   lower_any;
    logic [PREG_NUM-1:0] onehot;

    assign lower_any[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < PREG_NUM; gi++) begin : g_chain
            assign onehot[gi]      = mask[gi] & ~lower_any[gi];
            assign lower_any[gi+1] = lower_any[gi] | mask[gi];
        end
    endgenerate

    assign found = lower_any[PREG_NUM];

    // One-hot to binary: at most one term is non-zero
    always_comb begin
        preg = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            if (onehot[i]) begin
                preg = preg | preg_t'(i);
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Free list for the physical register pool. Grants the lowest free preg to
// rename each cycle, reclaims one preg per cycle from commit, and keeps a
// registered free bitmap, free count and empty flag.
// Optional branch checkpoint/rollback is built when FREE_LIST_CKPT_EN is defined.
module phys_reg_free_list
    import rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    phys_reg_free_list_if.slave  bus
);

    preg_mask_t bitmap_reg, bitmap_next;
    count_t     free_count_reg, free_count_next;
    logic       empty_reg, empty_next;
    logic       err_reg, err_next;

    logic       found;
    preg_t      sel_preg;
    logic       gnt;
    logic       rel_en;
    logic       dbl_free;
    logic       restore_en;
    logic       gnt_block;
    preg_mask_t restore_map;

    lowest_free_finder u_finder (
        .mask  (bitmap_reg),
        .found (found),
        .preg  (sel_preg)
    );

    // Released pregs are only visible next cycle, so grant looks at bitmap_reg alone
    assign gnt    = bus.alloc_req & ~empty_reg & found & ~gnt_block;
    assign rel_en = bus.rel_valid & (bus.rel_preg != '0);

`ifdef FREE_LIST_CKPT_EN
    preg_mask_t shadow_reg;
    preg_mask_t rel_since_reg;
    logic       ckpt_valid_reg;

    assign restore_en  = bus.ckpt_restore & ckpt_valid_reg;
    assign restore_map = shadow_reg | rel_since_reg;
    assign gnt_block   = bus.ckpt_restore;

    // Snapshot register; restore wins over save, and a restore drops any save
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg     <= '0;
            rel_since_reg  <= '0;
            ckpt_valid_reg <= 1'b0;
        end else if (bus.ckpt_restore) begin
            if (ckpt_valid_reg) begin
                ckpt_valid_reg <= 1'b0;
            end
        end else if (bus.ckpt_save) begin
            shadow_reg     <= bitmap_next;
            rel_since_reg  <= '0;
            ckpt_valid_reg <= 1'b1;
        end else if (ckpt_valid_reg && rel_en) begin
            rel_since_reg[bus.rel_preg] <= 1'b1;
        end
    end

    assign bus.ckpt_valid = ckpt_valid_reg;
`else
    logic unused_ckpt;

    assign unused_ckpt    = bus.ckpt_save ^ bus.ckpt_restore;
    assign restore_en     = 1'b0;
    assign restore_map    = '0;
    assign gnt_block      = 1'b0;
    assign bus.ckpt_valid = 1'b0;
`endif

    // Next bitmap: optional rollback, then grant and release on top; count follows
    always_comb begin
        dbl_free        = rel_en & bitmap_reg[bus.rel_preg];
        bitmap_next     = restore_en ? restore_map : bitmap_reg;
        if (gnt) begin
            bitmap_next[sel_preg] = 1'b0;
        end
        if (rel_en && !dbl_free) begin
            bitmap_next[bus.rel_preg] = 1'b1;
        end
        bitmap_next[0]  = 1'b0;         // $zero is never free
        err_next        = err_reg | dbl_free;
        free_count_next = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            free_count_next = free_count_next + count_t'(bitmap_next[i]);
        end
        empty_next      = (free_count_next == '0);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_reg     <= reset_mask();
            free_count_reg <= count_t'(PREG_NUM - AREG_NUM);
            empty_reg      <= (PREG_NUM == AREG_NUM);
            err_reg        <= 1'b0;
        end else begin
            bitmap_reg     <= bitmap_next;
            free_count_reg <= free_count_next;
            empty_reg      <= empty_next;
            err_reg        <= err_next;
        end
    end

    assign bus.alloc_gnt       = gnt;
    assign bus.alloc_preg      = sel_preg;
    assign bus.free_count      = free_count_reg;
    assign bus.empty           = empty_reg;
    assign bus.err_double_free = err_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list. The driver issues one directed
// vector per cycle and queues its hand-computed response; the monitor pops
// and compares the combinational grant mid-cycle and the registered state
// just after the edge. Checkpoint cases are built with FREE_LIST_CKPT_EN.
module tb_phys_reg_free_list;

    logic clk;
    logic rst_n;
    int   errors  = 0;
    int   checks  = 0;
    int   pending = 0;

    typedef struct {
        string      tag;
        logic       eg;
        logic [5:0] ep;
        logic [6:0] ec;
        logic       ee;
        logic       eerr;
        logic       ecv;
    } exp_t;

    exp_t sb[$];

    phys_reg_free_list_if fl_if ();

    phys_reg_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic set_inputs(input logic req, input logic rv, input logic [5:0] rp,
                              input logic sv, input logic rs);
        fl_if.alloc_req    = req;
        fl_if.rel_valid    = rv;
        fl_if.rel_preg     = rp;
        fl_if.ckpt_save    = sv;
        fl_if.ckpt_restore = rs;
    endtask

    // One cycle of stimulus plus its expected response
    task automatic step(input string tag, input logic req, input logic rv, input logic [5:0] rp,
                        input logic sv, input logic rs, input logic eg, input logic [5:0] ep,
                        input logic [6:0] ec, input logic ee, input logic eerr, input logic ecv);
        exp_t e;
        @(negedge clk);
        set_inputs(req, rv, rp, sv, rs);
        e.tag = tag; e.eg = eg; e.ep = ep; e.ec = ec; e.ee = ee; e.eerr = eerr; e.ecv = ecv;
        sb.push_back(e);
        pending++;
    endtask

    // Monitor: grant checked mid-low-phase, registered outputs after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".gnt"}, 32'(fl_if.alloc_gnt), 32'(e.eg));
                if (e.eg) chk({e.tag, ".preg"}, 32'(fl_if.alloc_preg), 32'(e.ep));
                $display("txn %s: gnt=%0b preg=%0d", e.tag, fl_if.alloc_gnt, fl_if.alloc_preg);
                @(posedge clk);
                #1;
                chk({e.tag, ".count"}, 32'(fl_if.free_count), 32'(e.ec));
                chk({e.tag, ".empty"}, 32'(fl_if.empty), 32'(e.ee));
                chk({e.tag, ".err"},   32'(fl_if.err_double_free), 32'(e.eerr));
                chk({e.tag, ".ckptv"}, 32'(fl_if.ckpt_valid), 32'(e.ecv));
                pending--;
            end
        end
    end

    task automatic drain();
        @(negedge clk);
        set_inputs(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && pending != 0; k++) @(posedge clk);
        chk("drain_done", 32'(pending == 0), 32'd1);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"}, 32'(fl_if.free_count), 32'd32);
        chk({tag, ".empty"}, 32'(fl_if.empty), 32'd0);
        chk({tag, ".err"},   32'(fl_if.err_double_free), 32'd0);
        chk({tag, ".ckptv"}, 32'(fl_if.ckpt_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_inputs(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        set_inputs(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

        // Drain the pool: grants 32..63 in order, then empty blocks the request
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step($sformatf("drain%0d", i), 1, 0, 0, 0, 0, 1, 6'(32 + i), 7'(31 - i), (i == 31), 0, 0);
        end
        step("empty_req", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Release while empty: no bypass, visible next cycle
        step("rel5_nobypass", 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        step("gnt5", 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0);
        drain();

        // Double free and $zero release
        do_reset();
        step("dbl40", 0, 1, 40, 0, 0, 0, 0, 32, 0, 1, 0);
        step("rel0", 0, 1, 0, 0, 0, 0, 0, 32, 0, 1, 0);
        step("err_sticky", 0, 0, 0, 0, 0, 0, 0, 32, 0, 1, 0);
        drain();

        // Same-cycle alloc + release
        do_reset();
        step("g32", 1, 0, 0, 0, 0, 1, 32, 31, 0, 0, 0);
        step("g33", 1, 0, 0, 0, 0, 1, 33, 30, 0, 0, 0);
        step("g34", 1, 0, 0, 0, 0, 1, 34, 29, 0, 0, 0);
        step("g35_rel33", 1, 1, 33, 0, 0, 1, 35, 29, 0, 0, 0);
        step("g33_again", 1, 0, 0, 0, 0, 1, 33, 28, 0, 0, 0);
        step("g36", 1, 0, 0, 0, 0, 1, 36, 27, 0, 0, 0);
`ifndef FREE_LIST_CKPT_EN
        // Without checkpoints, restore must not block the grant
        step("nockpt_restore", 1, 0, 0, 1, 1, 1, 37, 26, 0, 0, 0);
`endif
        drain();

`ifdef FREE_LIST_CKPT_EN
        // Save after 32..33, grant 34/35, release 10, restore
        do_reset();
        step("c_g32", 1, 0, 0, 0, 0, 1, 32, 31, 0, 0, 0);
        step("c_g33_save", 1, 0, 0, 1, 0, 1, 33, 30, 0, 0, 1);
        step("c_g34", 1, 0, 0, 0, 0, 1, 34, 29, 0, 0, 1);
        step("c_g35", 1, 0, 0, 0, 0, 1, 35, 28, 0, 0, 1);
        step("c_rel10", 0, 1, 10, 0, 0, 0, 0, 29, 0, 0, 1);
        step("c_restore", 1, 0, 0, 0, 1, 0, 0, 31, 0, 0, 0);
        step("c_g10", 1, 0, 0, 0, 0, 1, 10, 30, 0, 0, 0);
        step("c_g34b", 1, 0, 0, 0, 0, 1, 34, 29, 0, 0, 0);
        drain();

        // Save + restore together restores the old snapshot, takes no new one
        do_reset();
        step("s_save", 0, 0, 0, 1, 0, 0, 0, 32, 0, 0, 1);
        step("s_g32", 1, 0, 0, 0, 0, 1, 32, 31, 0, 0, 1);
        step("s_g33", 1, 0, 0, 0, 0, 1, 33, 30, 0, 0, 1);
        step("s_save_restore", 1, 0, 0, 1, 1, 0, 0, 32, 0, 0, 0);
        step("s_g32b", 1, 0, 0, 0, 0, 1, 32, 31, 0, 0, 0);
        step("s_dbl40_save", 0, 1, 40, 1, 0, 0, 0, 31, 0, 1, 1);
        step("s_g33b", 1, 0, 0, 0, 0, 1, 33, 30, 0, 1, 1);
        drain();
`else
        do_reset();
        step("s_dbl40", 0, 1, 40, 0, 0, 0, 0, 32, 0, 1, 0);
        step("s_g32", 1, 0, 0, 0, 0, 1, 32, 31, 0, 1, 0);
        drain();
`endif

        // Asynchronous reset mid-cycle: outputs return at once
        @(negedge clk);
        #3;
        fl_if.alloc_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        chk("async_rst.gnt",  32'(fl_if.alloc_gnt), 32'd1);
        chk("async_rst.preg", 32'(fl_if.alloc_preg), 32'd32);
        @(negedge clk);
        #1 rst_n = 1'b1;
        fl_if.alloc_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocator/scheduler for the 64-entry physical register pool used by the rename path (register map table → instruction queue).
- Grants one free physical register per cycle to rename and reclaims one per cycle from commit.
- Keeps a registered free bitmap and count.
- Optional branch checkpoint allows the free list to be rolled back on misprediction.

Parameters:
- PREG_NUM, 64, number of physical registers; must be a power of two.
- AREG_NUM, 32, architectural registers; pregs 0..AREG_NUM-1 are busy at reset (identity map).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- alloc_req  in  1  rename requests one physical register this cycle
- alloc_gnt  out  1  grant; combinational, same cycle as alloc_req
- alloc_preg  out  6  granted preg: the lowest-numbered free preg; valid only when alloc_gnt=1
- rel_valid  in  1  commit releases a preg this cycle
- rel_preg  in  6  preg to release
- free_count  out  7  registered number of free pregs
- empty  out  1  registered; 1 when free_count==0
- err_double_free  out  1  sticky; set on release of an already-free preg
- ckpt_save  in  1  snapshot the free list (branch renamed)
- ckpt_restore  in  1  roll back to the snapshot (mispredict)
- ckpt_valid  out  1  snapshot held

Behaviour:
- Reset (async, rst_n=0):
  - bitmap[i]=1 (free) for i>=AREG_NUM, 0 otherwise
  - free_count=32, empty=0, err_double_free=0, ckpt_valid=0
  - shadow and rel_since are cleared.
- Grant: alloc_gnt = alloc_req & !empty & !ckpt_restore.
  - The selected bit is cleared at the next posedge.
  - No partial grant; a requester that sees alloc_gnt=0 holds alloc_req.
- Release: when rel_valid=1, bitmap[rel_preg] is set at the next posedge.
  - A released preg is not grantable in the same cycle (no bypass). It becomes visible the following cycle.
- Preg 0 ($zero) is never granted or freed.
  - rel_preg==0 is ignored.
  - Bit 0 stays 0 permanently.
- Double free: rel_valid=1 with the bitmap bit already 1 → bitmap unchanged, err_double_free←1. The flag is cleared only by reset.
- Same cycle alloc + release:
  - both take effect;
  - free_count_next = free_count - gnt + (valid release);
  - alloc_preg never equals the preg being released that cycle.
- free_count and empty are updated from the next-state bitmap, so they are consistent with the bitmap every cycle. Width is 7 bits so the count can represent 64.
- Full pool (all non-zero pregs free) → any further release is a double free.

Optional Feature:
- FREE_LIST_CKPT_EN defined:
  - ckpt_save: shadow ← next-state bitmap (includes this cycle's grant and release), rel_since ← 0, ckpt_valid ← 1.
  - Every valid release while ckpt_valid=1 sets rel_since[rel_preg].
  - ckpt_restore with ckpt_valid=1:
    - bitmap ← shadow | rel_since, then this cycle's release is applied on top;
    - alloc_gnt is forced to 0;
    - ckpt_valid ← 0.
  - Restore has priority over save in the same cycle; the save is dropped.
  - Restore with ckpt_valid=0 is ignored, apart from the alloc_gnt block.
- FREE_LIST_CKPT_EN undefined:
  - ckpt inputs are ignored and ckpt_valid is tied to 0;
  - alloc_gnt does not depend on ckpt_restore;
  - no shadow or rel_since storage is built.

Decomposition:
- Shared package `rename_pkg`: PREG_NUM, AREG_NUM, `typedef logic [5:0] preg_t`, `typedef logic [PREG_NUM-1:0] preg_mask_t`.
- Sub-module `lowest_free_finder`: combinational priority encoder over preg_mask_t → {found, preg_t}.
- Popcount stays inline.

Test Plan:
- Reset, then alloc_req=1 for 32 consecutive cycles → grants 32..63 in order; free_count counts 32→0; empty=1 after the 32nd edge; the 33rd request gets alloc_gnt=0.
- From empty, rel_valid with rel_preg=5 and alloc_req=1 in the same cycle → alloc_gnt=0 that cycle. Next cycle alloc_gnt=1 and alloc_preg=5.
- After reset, rel_preg=40 (already free) → err_double_free=1 and stays 1; free_count stays 32. rel_preg=0 → no change.
- Grant 32, 33, 34, then release 33 with alloc in the same cycle → that cycle grants 35; next grant is 33; free_count is correct each cycle.
- CKPT_EN:
  - save after granting 32..33;
  - grant 34, 35; release 10;
  - restore → free bitmap = {34..63, 10}; free_count=31; ckpt_valid=0; alloc_gnt=0 in the restore cycle.
- CKPT_EN: save and restore asserted together with ckpt_valid=1 → restores the old snapshot, no new snapshot taken. Assert rst_n=0 mid-sequence → all outputs return to reset values immediately.
